// File: rtl/ifb_pkg.sv
// Shared types and sizing helpers for the instruction fetch buffer.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package ifb_pkg;

    // Default field widths; the top module exposes these as overridable parameters.
    localparam int IFB_WORD_W   = 8;
    localparam int IFB_OPCODE_W = 4;
    localparam int IFB_PC_W     = 8;
    localparam int IFB_DEPTH    = 4;
    localparam int IFB_INSTR_W  = IFB_OPCODE_W + IFB_WORD_W;

    // One prefetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [IFB_PC_W-1:0]    pc;
        logic [IFB_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Occupancy counters must be able to hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Read/write pointers index DEPTH slots and wrap naturally (DEPTH is a power of two).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of fetch entries with flush and occupancy count.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push into a full FIFO is ignored unless a pop happens in the same cycle.
module ifb_fifo
    import ifb_pkg::*;
#(
    parameter  int  DEPTH   = IFB_DEPTH,
    parameter  type entry_t = fetch_entry_t,
    localparam int  PTR_W   = ptr_w(DEPTH),
    localparam int  CNT_W   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  entry_t           i_push_dat,
    input  logic             i_pop,
    output entry_t           o_head_dat,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    // Pop is evaluated first, so a full FIFO can accept a push in the same cycle it pops.
    always_comb begin
        w_full    = (r_count == CNT_W'(DEPTH));
        w_do_pop  = i_pop && (r_count != '0);
        w_do_push = i_push && (!w_full || w_do_pop);
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Entry storage; contents of empty slots are never observed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush && !reset) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Fetch stage: issues sequential imem requests, queues in-order responses, loads IR on ld_instr; IFB_BYPASS_EN lets a response load IR directly.
// Latency: zero-wait memory gives request in cycle 1 after reset, FIFO write at edge 2, IR load at edge 3 (edge 2 with bypass).
// Backpressure: requests stop while queued plus in-flight entries would exceed DEPTH; ld_instr with nothing available raises stall.
module instruction_fetch_buffer
    import ifb_pkg::*;
#(
    parameter  int WORD_W   = IFB_WORD_W,
    parameter  int OPCODE_W = IFB_OPCODE_W,
    parameter  int PC_W     = IFB_PC_W,
    parameter  int DEPTH    = IFB_DEPTH,
    localparam int INSTR_W  = OPCODE_W + WORD_W,
    localparam int CNT_W    = cnt_w(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic                ld_instr,
    input  logic                pc_load,
    input  logic [PC_W-1:0]     pc_load_value,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                ir_valid,
    output logic [OPCODE_W-1:0] instruction_code,
    output logic [WORD_W-1:0]   instruction_value,
    output logic [PC_W-1:0]     ir_pc,
    output logic                stall,
    output logic [CNT_W-1:0]    fifo_count
);

    // Queue entry sized from this instance's parameters.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    // Architectural state.
    logic [PC_W-1:0]    r_pc;            // next address to request
    logic [PC_W-1:0]    r_ret_pc;        // address tag of the next kept response
    logic [CNT_W-1:0]   r_outstanding;   // accepted requests not yet returned
    logic [CNT_W-1:0]   r_drop;          // in-flight responses belonging to a flushed stream
    logic [INSTR_W-1:0] r_ir;
    logic [PC_W-1:0]    r_ir_pc;
    logic               r_ir_valid;

    // Per-cycle decisions.
    logic               w_req;
    logic               w_accept;
    logic               w_rsp;
    logic               w_rsp_keep;
    logic               w_rsp_drop;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic               w_stall;
    logic [CNT_W:0]     w_occupancy;
    logic [CNT_W-1:0]   w_outstanding_nxt;
    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_fifo_empty;
    entry_t             w_push_dat;
    entry_t             w_head_dat;

    // Direct response-to-IR path, only when the queue is empty and the response is live.
`ifdef IFB_BYPASS_EN
    assign w_bypass = w_rsp_keep && ld_instr && !pc_load && w_fifo_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // Request issue, response classification, queue control and stall.
    always_comb begin
        w_occupancy       = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
        // Reserving a slot per in-flight request guarantees every response has room.
        w_req             = !reset && ce && (w_occupancy < (CNT_W+1)'(DEPTH));
        w_accept          = w_req && imem_ready;
        // A response with nothing outstanding is a protocol error and is ignored.
        w_rsp             = imem_rvalid && (r_outstanding != '0);
        w_rsp_keep        = w_rsp && (r_drop == '0);
        w_rsp_drop        = w_rsp && (r_drop != '0);
        w_outstanding_nxt = r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp);
        w_push            = w_rsp_keep && !w_bypass && !pc_load;
        w_push_dat.pc     = r_ret_pc;
        w_push_dat.instr  = imem_rdata;
        // Redirect outranks a load request in the same cycle.
        w_pop             = ld_instr && !pc_load && !w_fifo_empty;
        w_stall           = ld_instr && !pc_load && !reset && w_fifo_empty && !w_bypass;
    end

    ifb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (pc_load),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count)
    );

    // Fetch address: advance on each accepted request, jump on redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else if (pc_load) begin
            r_pc <= pc_load_value;
        end else if (w_accept) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    // Return tag: follows kept responses so each queued entry carries its own address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ret_pc <= '0;
        end else if (pc_load) begin
            r_ret_pc <= pc_load_value;
        end else if (w_rsp_keep) begin
            r_ret_pc <= r_ret_pc + PC_W'(1);
        end
    end

    // In-flight accounting; on redirect everything still in flight (including this cycle's accept) is marked for discard.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (pc_load) begin
                r_drop <= w_outstanding_nxt;
            end else if (w_rsp_drop) begin
                r_drop <= r_drop - CNT_W'(1);
            end
        end
    end

    // Instruction register: load from queue head or bypass; redirect invalidates it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
        end else if (pc_load) begin
            r_ir_valid <= 1'b0;
        end else if (w_pop) begin
            r_ir       <= w_head_dat.instr;
            r_ir_pc    <= w_head_dat.pc;
            r_ir_valid <= 1'b1;
        end else if (w_bypass) begin
            r_ir       <= imem_rdata;
            r_ir_pc    <= r_ret_pc;
            r_ir_valid <= 1'b1;
        end
    end

    assign imem_req          = w_req;
    assign imem_addr         = r_pc;
    assign ir_valid          = r_ir_valid;
    assign instruction_code  = r_ir[INSTR_W-1:WORD_W];
    assign instruction_value = r_ir[WORD_W-1:0];
    assign ir_pc             = r_ir_pc;
    assign stall             = w_stall;
    assign fifo_count        = w_fifo_count;

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Self-checking bench for instruction_fetch_buffer (default parameters).
// Latency: per-cycle vector table plus multi-cycle sequences against an in-order memory model.
// Backpressure: memory readiness is driven directly by the bench.
module tb_instruction_fetch_buffer;

    localparam int NV = 20;
`ifdef IFB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ce, ld_instr, pc_load, imem_ready;
    logic [7:0]  pc_load_value;
    logic        tb_rvalid;
    logic [11:0] tb_rdata;
    logic        mdl_rvalid = 1'b0;
    logic [11:0] mdl_rdata  = 12'h000;
    logic        mem_en     = 1'b0;
    logic        imem_rvalid;
    logic [11:0] imem_rdata;

    logic        imem_req, ir_valid, stall;
    logic [7:0]  imem_addr, ir_pc;
    logic [3:0]  instruction_code;
    logic [7:0]  instruction_value;
    logic [2:0]  fifo_count;

    int n_chk  = 0;
    int n_pass = 0;
    int edges  = 0;
    int mdl_lat = 1;

    assign imem_rvalid = mem_en ? mdl_rvalid : tb_rvalid;
    assign imem_rdata  = mem_en ? mdl_rdata  : tb_rdata;

    instruction_fetch_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .ce                (ce),
        .ld_instr          (ld_instr),
        .pc_load           (pc_load),
        .pc_load_value     (pc_load_value),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .ir_valid          (ir_valid),
        .instruction_code  (instruction_code),
        .instruction_value (instruction_value),
        .ir_pc             (ir_pc),
        .stall             (stall),
        .fifo_count        (fifo_count)
    );

    // In-order memory model: response for an accept at edge e is presented in the cycle after edge e+lat-1; data = 0x100 + addr.
    typedef struct { logic [7:0] addr; int due; } pend_t;
    pend_t q[$];

    always @(posedge clk) begin
        if (mdl_rvalid && q.size() > 0) void'(q.pop_front());
        edges++;
        if (!mem_en) q.delete();
        else if (imem_req && imem_ready) q.push_back('{imem_addr, edges + mdl_lat - 1});
    end

    always @(negedge clk) begin
        if (mem_en && q.size() > 0 && q[0].due <= edges) begin
            mdl_rvalid = 1'b1;
            mdl_rdata  = 12'h100 + {4'h0, q[0].addr};
        end else begin
            mdl_rvalid = 1'b0;
            mdl_rdata  = 12'h000;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic rst, ce, ld, pl; logic [7:0] plv; logic rdy, rv; logic [11:0] rd;
        logic e_req; logic [7:0] e_addr; logic [2:0] e_cnt; logic e_irv;
        logic [11:0] e_ir; logic [7:0] e_irpc; logic e_stall;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic c, input logic ld, input logic pl,
                                input logic [7:0] plv, input logic rdy, input logic rv, input logic [11:0] rd,
                                input logic e_req, input logic [7:0] e_addr, input logic [2:0] e_cnt,
                                input logic e_irv, input logic [11:0] e_ir, input logic [7:0] e_irpc,
                                input logic e_stall);
        vec_t v;
        v.rst = rst; v.ce = c; v.ld = ld; v.pl = pl; v.plv = plv; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_cnt = e_cnt; v.e_irv = e_irv;
        v.e_ir = e_ir; v.e_irpc = e_irpc; v.e_stall = e_stall;
        return v;
    endfunction

    // Reset pulse with all requesters idle; leaves the bench at the negedge where reset drops.
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        reset = 1'b1; ce = 1'b0; ld_instr = 1'b0; pc_load = 1'b0; imem_ready = rdy;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t tv [NV];
    int   k;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            rst ce ld pl plv   rdy rv rd      req addr  cnt       irv ir                 irpc             stall
        tv[0]  = mk(1, 1, 1, 0, 8'h00, 1, 0, 12'h000, 0, 8'h00, 3'd0, 0, 12'h000, 8'h00, 0);
        tv[1]  = mk(0, 1, 0, 0, 8'h00, 1, 0, 12'h000, 1, 8'h00, 3'd0, 0, 12'h000, 8'h00, 0);
        tv[2]  = mk(0, 1, 0, 0, 8'h00, 1, 1, 12'h100, 1, 8'h01, 3'd0, 0, 12'h000, 8'h00, 0);
        tv[3]  = mk(0, 1, 1, 0, 8'h00, 1, 1, 12'h101, 1, 8'h02, 3'd1, 0, 12'h000, 8'h00, 0);
        tv[4]  = mk(0, 0, 1, 0, 8'h00, 1, 1, 12'h102, 0, 8'h03, 3'd1, 1, 12'h100, 8'h00, 0);
        tv[5]  = mk(0, 0, 1, 0, 8'h00, 1, 1, 12'hABC, 0, 8'h03, 3'd1, 1, 12'h101, 8'h01, 0);
        tv[6]  = mk(0, 0, 1, 0, 8'h00, 1, 0, 12'h000, 0, 8'h03, 3'd0, 1, 12'h102, 8'h02, 1);
        tv[7]  = mk(0, 0, 0, 0, 8'h00, 1, 0, 12'h000, 0, 8'h03, 3'd0, 1, 12'h102, 8'h02, 0);
        tv[8]  = mk(0, 1, 1, 0, 8'h00, 0, 0, 12'h000, 1, 8'h03, 3'd0, 1, 12'h102, 8'h02, 1);
        tv[9]  = mk(0, 1, 1, 1, 8'hFE, 1, 0, 12'h000, 1, 8'h03, 3'd0, 1, 12'h102, 8'h02, 0);
        tv[10] = mk(0, 1, 0, 0, 8'h00, 1, 1, 12'h777, 1, 8'hFE, 3'd0, 0, 12'h102, 8'h02, 0);
        tv[11] = mk(0, 1, 0, 0, 8'h00, 1, 1, 12'h1FE, 1, 8'hFF, 3'd0, 0, 12'h102, 8'h02, 0);
        tv[12] = mk(0, 1, 1, 0, 8'h00, 1, 1, 12'h1FF, 1, 8'h00, 3'd1, 0, 12'h102, 8'h02, 0);
        tv[13] = mk(0, 0, 1, 0, 8'h00, 1, 1, 12'h200, 0, 8'h01, 3'd1, 1, 12'h1FE, 8'hFE, 0);
        tv[14] = mk(0, 0, 1, 0, 8'h00, 1, 0, 12'h000, 0, 8'h01, 3'd1, 1, 12'h1FF, 8'hFF, 0);
        tv[15] = mk(0, 1, 0, 0, 8'h00, 1, 0, 12'h000, 1, 8'h01, 3'd0, 1, 12'h200, 8'h00, 0);
        tv[16] = mk(0, 0, 1, 0, 8'h00, 1, 1, 12'h301, 0, 8'h02, 3'd0, 1, 12'h200, 8'h00, !BYP);
        tv[17] = mk(0, 0, 0, 0, 8'h00, 1, 0, 12'h000, 0, 8'h02, BYP ? 3'd0 : 3'd1, 1,
                    BYP ? 12'h301 : 12'h200, BYP ? 8'h01 : 8'h00, 0);
        tv[18] = mk(0, 0, 1, 0, 8'h00, 1, 0, 12'h000, 0, 8'h02, BYP ? 3'd0 : 3'd1, 1,
                    BYP ? 12'h301 : 12'h200, BYP ? 8'h01 : 8'h00, BYP);
        tv[19] = mk(0, 0, 0, 0, 8'h00, 1, 0, 12'h000, 0, 8'h02, 3'd0, 1, 12'h301, 8'h01, 0);

        reset = 1'b1; ce = 1'b0; ld_instr = 1'b0; pc_load = 1'b0; pc_load_value = 8'h00;
        imem_ready = 1'b0; tb_rvalid = 1'b0; tb_rdata = 12'h000; mem_en = 1'b0;
        repeat (2) @(negedge clk);

        // Directed per-cycle vectors: reset, handshake, protocol error, stall, redirect drop, pc wrap, bypass case.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset = tv[i].rst; ce = tv[i].ce; ld_instr = tv[i].ld; pc_load = tv[i].pl;
            pc_load_value = tv[i].plv; imem_ready = tv[i].rdy; tb_rvalid = tv[i].rv; tb_rdata = tv[i].rd;
            #1;
            check($sformatf("row%0d imem_req", i),   imem_req,   tv[i].e_req);
            check($sformatf("row%0d imem_addr", i),  imem_addr,  tv[i].e_addr);
            check($sformatf("row%0d fifo_count", i), fifo_count, tv[i].e_cnt);
            check($sformatf("row%0d ir_valid", i),   ir_valid,   tv[i].e_irv);
            check($sformatf("row%0d stall", i),      stall,      tv[i].e_stall);
            if (tv[i].e_irv) begin
                check($sformatf("row%0d ir", i), {instruction_code, instruction_value}, tv[i].e_ir);
                check($sformatf("row%0d ir_pc", i), ir_pc, tv[i].e_irpc);
            end
        end
        tb_rvalid = 1'b0;

        // Zero-wait memory, ld_instr held: one instruction per cycle after the first load.
        mem_en = 1'b1; mdl_lat = 1;
        do_reset(1'b1);
        ce = 1'b1; ld_instr = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk); #1;
            if (n >= (BYP ? 2 : 3)) begin
                check($sformatf("thru%0d ir_valid", n), ir_valid, 1);
                check($sformatf("thru%0d ir", n), {instruction_code, instruction_value}, 12'h100 + n - (BYP ? 2 : 3));
                check($sformatf("thru%0d ir_pc", n), ir_pc, n - (BYP ? 2 : 3));
            end else begin
                check($sformatf("thru%0d ir_valid", n), ir_valid, 0);
            end
            check($sformatf("thru%0d stall", n), stall, (n >= 2) ? 0 : !BYP);
        end

        // Memory not ready: address holds, nothing returns, load request stalls.
        do_reset(1'b0);
        ce = 1'b1;
        #1;
        for (int n = 0; n < 6; n++) begin
            check($sformatf("nrdy%0d imem_req", n), imem_req, 1);
            check($sformatf("nrdy%0d imem_addr", n), imem_addr, 0);
            check($sformatf("nrdy%0d rvalid", n), imem_rvalid, 0);
            check($sformatf("nrdy%0d fifo_count", n), fifo_count, 0);
            @(negedge clk); #1;
        end
        ld_instr = 1'b1; #1;
        check("nrdy stall", stall, 1);

        // No loads: queue fills to DEPTH, requests stop, nothing left in flight; then drain in order.
        do_reset(1'b1);
        ce = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("sat fifo_count", fifo_count, 4);
        check("sat imem_req", imem_req, 0);
        check("sat imem_addr", imem_addr, 4);
        check("sat in_flight", q.size(), 0);
        @(negedge clk);
        ld_instr = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk); #1;
            check($sformatf("drain%0d ir", n), {instruction_code, instruction_value}, 12'h100 + n);
            check($sformatf("drain%0d ir_pc", n), ir_pc, n);
        end

        // Three-cycle latency, redirect with two responses in flight: both discarded.
        mdl_lat = 3;
        do_reset(1'b1);
        ce = 1'b1;
        repeat (2) @(negedge clk);
        pc_load = 1'b1; pc_load_value = 8'h40; ce = 1'b0;
        #1;
        check("redir in_flight", q.size(), 2);
        check("redir ir_valid", ir_valid, 1'b0);
        @(negedge clk);
        pc_load = 1'b0; ce = 1'b1; ld_instr = 1'b1;
        #1;
        check("redir ir_valid_clr", ir_valid, 0);
        k = 0;
        while (!ir_valid && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        check("redir wait ir_valid", ir_valid, 1);
        check("redir ir_pc", ir_pc, 8'h40);
        check("redir ir", {instruction_code, instruction_value}, 12'h140);
        @(negedge clk); #1;
        check("redir next ir_pc", ir_pc, 8'h41);
        check("redir next ir", {instruction_code, instruction_value}, 12'h141);

        // Reset with requests in flight: late responses are ignored afterwards.
        do_reset(1'b1);
        ce = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1; ce = 1'b0;
        #1;
        check("rst req_low", imem_req, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk); #1;
            check($sformatf("late%0d fifo_count", n), fifo_count, 0);
        end
        ld_instr = 1'b1; #1;
        check("late stall", stall, 1);
        check("late ir_valid", ir_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
